trigger_capture: RTL and testbench

Capture stage directly upstream of the trigger ROM copy stage. It records a continuous ADC sample stream into a circular buffer and detects a level-crossing trigger. Around the trigger it assembles a DEPTH-sample frame with PRETRIG pre-trigger samples and presents it as an unpacked array. It then issues a one-cycle read request to the downstream copy stage and holds the frame stable until that stage has finished copying.

---
 rtl/trigger_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_trigger_capture.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture
// Brief    : Circular-buffer ADC capture with level-crossing trigger; hands a
//            DEPTH-sample frame to the downstream copy stage.
// Revision : 1.0
// ============================================================================

module trigger_capture #(
    parameter int WIDTH   = 12,
    parameter int DEPTH   = 256,
    parameter int PRETRIG = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             arm,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_falling,
    input  logic             force_trig,
    input  logic             rom_ready,
    output logic             read,
    output logic             busy,
    output logic             frame_valid,
    output logic [WIDTH-1:0] data [0:DEPTH-1]
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] c_pretrig_ptr = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] c_last_idx    = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_pre_last    = CNT_W'(PRETRIG - 1);
    localparam logic [CNT_W-1:0]  c_post_len    = CNT_W'(DEPTH - PRETRIG);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_COPY      = 3'd4,
        S_REQ       = 3'd5,
        S_HOLD      = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_start_ptr;
    logic [ADDR_W-1:0]  r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   r_level;
    logic               r_falling;
    logic               r_seen_low;
    logic               r_read;
    logic               r_frame_valid;

    logic               w_capture;
    logic               w_edge;
    logic               w_trig;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ADDR_W-1:0]  w_rd_ptr;

    assign w_capture = adc_valid &&
                       ((r_state == S_PRE) || (r_state == S_WAIT_TRIG) || (r_state == S_POST));

    // Crossing is judged between the previous valid sample and the current one.
    assign w_edge = r_falling ? ((r_prev > r_level) && (adc_data <= r_level))
                              : ((r_prev < r_level) && (adc_data >= r_level));

    assign w_trig    = (r_state == S_WAIT_TRIG) && adc_valid && (w_edge || force_trig);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_rd_ptr  = r_start_ptr + r_idx;

    assign read        = r_read;
    assign busy        = (r_state != S_IDLE);
    assign frame_valid = r_frame_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_next_state = S_PRE;
                end
            end
            S_PRE: begin
                if (adc_valid && (r_cnt == c_pre_last)) begin
                    w_next_state = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (w_trig) begin
                    // With a single post-trigger slot the trigger sample completes the frame.
                    w_next_state = (c_post_len == CNT_W'(1)) ? S_COPY : S_POST;
                end
            end
            S_POST: begin
                if (adc_valid && (w_cnt_inc == c_post_len)) begin
                    w_next_state = S_COPY;
                end
            end
            S_COPY: begin
                if (r_idx == c_last_idx) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (rom_ready) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_seen_low && rom_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= adc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_start_ptr   <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_prev        <= '0;
            r_level       <= '0;
            r_falling     <= 1'b0;
            r_seen_low    <= 1'b0;
            r_read        <= 1'b0;
            r_frame_valid <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            r_read <= 1'b0;

            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_prev   <= adc_data;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_level       <= trig_level;
                        r_falling     <= trig_falling;
                        r_frame_valid <= 1'b0;
                        r_cnt         <= '0;
                        r_idx         <= '0;
                        r_seen_low    <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (adc_valid) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WAIT_TRIG: begin
                    if (w_trig) begin
                        r_start_ptr <= r_wr_ptr - c_pretrig_ptr;
                        r_cnt       <= CNT_W'(1);
                        r_idx       <= '0;
                    end
                end
                S_POST: begin
                    if (adc_valid) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_COPY: begin
                    data[r_idx] <= r_mem[w_rd_ptr];
                    r_idx       <= r_idx + ADDR_W'(1);
                    if (r_idx == c_last_idx) begin
                        r_frame_valid <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_seen_low <= 1'b0;
                    if (rom_ready) begin
                        r_read <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Downstream signals completion by dropping ready and raising it again.
                    if (!rom_ready) begin
                        r_seen_low <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_capture
// Brief    : Directed bench for trigger_capture with a sample-history model.
// Revision : 1.0
// ============================================================================

module tb_trigger_capture;

    localparam int WIDTH   = 12;
    localparam int DEPTH   = 256;
    localparam int PRETRIG = 64;

    logic             clk          = 1'b0;
    logic             rst          = 1'b1;
    logic [WIDTH-1:0] adc_data     = '0;
    logic             adc_valid    = 1'b0;
    logic             arm          = 1'b0;
    logic [WIDTH-1:0] trig_level   = '0;
    logic             trig_falling = 1'b0;
    logic             force_trig   = 1'b0;
    logic             rom_ready    = 1'b1;
    logic             read;
    logic             busy;
    logic             frame_valid;
    logic [WIDTH-1:0] data [0:DEPTH-1];

    int n_checks = 0;
    int n_errors = 0;
    int n_reads  = 0;

    always #5 clk = ~clk;

    trigger_capture #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PRETRIG (PRETRIG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .arm          (arm),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .force_trig   (force_trig),
        .rom_ready    (rom_ready),
        .read         (read),
        .busy         (busy),
        .frame_valid  (frame_valid),
        .data         (data)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Model: the frame is a window over the list of valid samples seen since arm.
    logic [WIDTH-1:0] m_samp [$];
    logic [WIDTH-1:0] m_data [0:DEPTH-1];
    logic [WIDTH-1:0] m_lvl      = '0;
    bit               m_fall     = 1'b0;
    bit               m_fv       = 1'b0;
    bit               m_read     = 1'b0;
    bit               m_seen_low = 1'b0;
    int               m_phase    = 0;   // 0 idle, 1 collecting, 2 copying, 3 requesting, 4 holding
    int               m_trig     = -1;
    int               m_ci       = 0;

    initial begin
        int               n;
        int               bad;
        logic [WIDTH-1:0] p;
        bit               hit;
        for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
        forever begin
            @(negedge clk);
            chk("busy", busy, m_phase != 0);
            chk("read", read, m_read);
            chk("frame_valid", frame_valid, m_fv);
            bad = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (bad < 0 && data[i] !== m_data[i]) bad = i;
            end
            n_checks++;
            if (bad >= 0) begin
                n_errors++;
                $display("FAIL data[%0d]: got %0d expected %0d", bad, data[bad], m_data[bad]);
            end
            if (read === 1'b1) n_reads++;

            m_read = 1'b0;
            if (rst) begin
                m_phase = 0;
                m_fv    = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
            end else begin
                case (m_phase)
                    0: if (arm) begin
                        m_phase = 1;
                        m_lvl   = trig_level;
                        m_fall  = trig_falling;
                        m_fv    = 1'b0;
                        m_trig  = -1;
                        m_samp.delete();
                    end
                    1: if (adc_valid) begin
                        m_samp.push_back(adc_data);
                        n = m_samp.size();
                        if (m_trig < 0 && n > PRETRIG) begin
                            p   = m_samp[n-2];
                            hit = m_fall ? (p > m_lvl && adc_data <= m_lvl)
                                         : (p < m_lvl && adc_data >= m_lvl);
                            if (hit || force_trig) m_trig = n - 1;
                        end
                        if (m_trig >= 0 && n - m_trig == DEPTH - PRETRIG) begin
                            m_phase = 2;
                            m_ci    = 0;
                        end
                    end
                    2: begin
                        m_data[m_ci] = m_samp[m_trig - PRETRIG + m_ci];
                        m_ci++;
                        if (m_ci == DEPTH) begin
                            m_fv    = 1'b1;
                            m_phase = 3;
                        end
                    end
                    3: if (rom_ready) begin
                        m_read     = 1'b1;
                        m_seen_low = 1'b0;
                        m_phase    = 4;
                    end
                    4: begin
                        if (!rom_ready) m_seen_low = 1'b1;
                        else if (m_seen_low) m_phase = 0;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [WIDTH-1:0] lvl, input logic fall);
        tick();
        arm          = 1'b1;
        trig_level   = lvl;
        trig_falling = fall;
        tick();
        arm = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] sval(input int mode, input int k);
        case (mode)
            0:       return WIDTH'(k);
            1: begin
                if (k < 64)      return '0;
                else if (k < 85) return WIDTH'(990 + k - 64);
                else             return WIDTH'(4095 - (k - 85));
            end
            default: return WIDTH'(500);
        endcase
    endfunction

    // poke_at: a stray arm plus a threshold change that must both be ignored.
    task automatic feed(input int mode, input int count, input bit gap,
                        input int force_at, input int poke_at);
        for (int k = 0; k < count; k++) begin
            tick();
            adc_valid  = 1'b1;
            adc_data   = sval(mode, k);
            force_trig = (k == force_at);
            if (k == poke_at) begin
                arm        = 1'b1;
                trig_level = '0;
            end else begin
                arm = 1'b0;
            end
            if (gap) begin
                tick();
                adc_valid  = 1'b0;
                force_trig = 1'b0;
                arm        = 1'b0;
                adc_data   = ~adc_data;
            end
        end
        tick();
        adc_valid  = 1'b0;
        force_trig = 1'b0;
        arm        = 1'b0;
    endtask

    task automatic serve(input int low_cycles);
        int n;
        n = 0;
        while (frame_valid !== 1'b1 && n < 8000) begin tick(); n++; end
        if (n >= 8000) timeout("frame_valid_wait");
        if (low_cycles > 0) begin
            repeat (low_cycles) tick();
            rom_ready = 1'b1;
        end
        n = 0;
        while (read !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) timeout("read_wait");
        else chk("read_latency", n, 1);
        rom_ready = 1'b0;
        repeat (4) tick();
        rom_ready = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(); n++; end
        if (n >= 20) timeout("busy_drop_wait");
    endtask

    task automatic chk_all(input string name, input logic [WIDTH-1:0] v);
        int bad;
        bad = -1;
        for (int i = 0; i < DEPTH; i++) if (bad < 0 && data[i] !== v) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL %s: data[%0d] got %0d expected %0d", name, bad, data[bad], v);
        end
    endtask

    initial begin
        int r0;

        // Reset state
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_read", read, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk_all("rst_data", '0);
        tick();
        rst = 1'b0;

        // Rising ramp with ignored stray arm / level change
        r0 = n_reads;
        do_arm(12'd2048, 1'b0);
        feed(0, 2260, 1'b0, -1, 100);
        serve(0);
        chk("ramp_d0", data[0], 1984);
        chk("ramp_d64", data[64], 2048);
        chk("ramp_d255", data[255], 2239);
        chk("ramp_reads", n_reads - r0, 1);
        chk("ramp_fv", frame_valid, 1);

        // Falling trigger, with an earlier rising crossing of the level
        r0 = n_reads;
        do_arm(12'd1000, 1'b1);
        feed(1, 3380, 1'b0, -1, -1);
        serve(0);
        chk("fall_d64", data[64], 1000);
        chk("fall_d63", data[63], 1001);
        chk("fall_d0", data[0], 1064);
        chk("fall_reads", n_reads - r0, 1);

        // Gapped valid
        do_arm(12'd2048, 1'b0);
        feed(0, 2260, 1'b1, -1, -1);
        serve(0);
        chk("gap_d0", data[0], 1984);
        chk("gap_d64", data[64], 2048);
        chk("gap_d255", data[255], 2239);

        // Forced trigger on a flat input
        do_arm(12'd2048, 1'b0);
        feed(2, 300, 1'b0, 80, -1);
        serve(0);
        chk_all("force_data", 12'd500);
        chk("force_fv", frame_valid, 1);

        // Handshake with rom_ready held low through the request
        r0 = n_reads;
        rom_ready = 1'b0;
        do_arm(12'd2048, 1'b0);
        feed(0, 2260, 1'b0, -1, -1);
        serve(50);
        chk("hs_reads", n_reads - r0, 1);
        chk("hs_d255", data[255], 2239);

        // Reset during post-trigger collection, then a clean capture
        do_arm(12'd2048, 1'b0);
        feed(0, 2100, 1'b0, -1, -1);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_read", read, 0);
        chk("post_rst_fv", frame_valid, 0);
        chk_all("post_rst_data", '0);
        do_arm(12'd2048, 1'b0);
        feed(0, 2260, 1'b0, -1, -1);
        serve(0);
        chk("recap_d0", data[0], 1984);
        chk("recap_d64", data[64], 2048);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
